golay24_dec_candidate_sel: RTL

Chase-decoder back end for the Golay(24,12) soft decoder. It consumes the per-frame candidate stream after each test pattern has been hard-decoded, and scores every candidate codeword against the channel LLRs using correlation discrepancy. When the frame's last candidate arrives, it emits the minimum-metric codeword. It is the receiving end of the candidate generator's sop/val/eop stream, placed after the algebraic hard decoder.

---
 rtl/golay24_dec_candidate_sel_pkg.sv | 25 ++
 rtl/golay24_dec_metric.sv | 40 ++++
 rtl/golay24_dec_candidate_sel.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/golay24_dec_candidate_sel_pkg.sv
// Shared Golay(24,12) soft-decoder types and helpers.
package golay24_dec_candidate_sel_pkg;

    localparam int unsigned CW_W     = 24;
    localparam int unsigned LLR_W    = 4;
    localparam int unsigned METRIC_W = LLR_W + 4;

    typedef logic [CW_W-1:0]            dat_t;
    typedef logic signed [LLR_W-1:0]    llr_t;
    typedef logic [METRIC_W-1:0]        metric_t;

    // Magnitude of a w-bit signed LLR held sign-extended in v. The most negative code is
    // clamped to 2^(w-1)-1 so that magnitudes stay symmetric around zero.
    function automatic logic [15:0] abs_clamp(input logic signed [15:0] v, input int unsigned w);
        logic [15:0] lim;
        logic [15:0] m;
        lim = 16'((32'd1 << (w - 1)) - 32'd1);
        m   = v[15] ? unsigned'(-v) : unsigned'(v);
        if (m > lim) begin
            m = lim;
        end
        return m;
    endfunction

endpackage

// File: rtl/golay24_dec_metric.sv
// Masked magnitude sum over 24 bit positions with a single registered output.
module golay24_dec_metric
    import golay24_dec_candidate_sel_pkg::*;
#(
    parameter int unsigned pMAG_W    = 3,
    parameter int unsigned pMETRIC_W = 8
) (
    input  logic                          iclk,
    input  logic                          ireset,
    input  logic                          iclkena,
    input  logic [CW_W-1:0]               imask,
    input  logic [CW_W-1:0][pMAG_W-1:0]   imag,
    output logic [pMETRIC_W-1:0]          ometric
);

    logic [pMETRIC_W-1:0] sum_d;
    logic [pMETRIC_W-1:0] sum_q;

    // Sum the magnitudes of the positions selected by the mask.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < int'(CW_W); i++) begin
            if (imask[i]) begin
                sum_d = sum_d + pMETRIC_W'(imag[i]);
            end
        end
    end

    // Register the sum.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            sum_q <= '0;
        end else if (iclkena) begin
            sum_q <= sum_d;
        end
    end

    assign ometric = sum_q;

endmodule

// File: rtl/golay24_dec_candidate_sel.sv
// Chase-decoder back end: scores candidates by correlation discrepancy and reports the best
// codeword of each frame three enabled cycles after its last candidate.
module golay24_dec_candidate_sel
    import golay24_dec_candidate_sel_pkg::*;
#(
    parameter int unsigned pLLR_W    = LLR_W,
    parameter int unsigned pMETRIC_W = pLLR_W + 4
) (
    input  logic                          iclk,
    input  logic                          ireset,
    input  logic                          iclkena,
    input  logic                          isop,
    input  logic                          ival,
    input  logic                          ieop,
    input  dat_t                          icw,
    input  logic                          idec_fail,
    input  logic [CW_W-1:0][pLLR_W-1:0]   illr,
    output logic                          oval,
    output dat_t                          odat,
    output logic [pMETRIC_W-1:0]          ometric,
    output logic [4:0]                    oerr,
    output logic                          ofail
);

    localparam int unsigned MAG_W = pLLR_W - 1;
    typedef logic [CW_W-1:0][MAG_W-1:0] mag_vec_t;

    // Frame capture
    dat_t                 hd_in, hd_cur, hd_d, hd_q;
    mag_vec_t             mag_in, mag_cur, mag_d, mag_q;
    logic                 in_frame_d, in_frame_q;
    logic                 take_sop, accept;
    // S1
    logic                 s1_val_d, s1_sop_d, s1_eop_d, s1_fail_d;
    logic                 s1_val_q, s1_sop_q, s1_eop_q, s1_fail_q;
    dat_t                 s1_diff_d, s1_cw_d, s1_hd_d, s1_diff_q, s1_cw_q, s1_hd_q;
    mag_vec_t             s1_mag_d, s1_mag_q;
    // S2
    logic                 s2_val_q, s2_sop_q, s2_eop_q, s2_fail_q;
    dat_t                 s2_cw_q, s2_hd_q;
    logic [pMETRIC_W-1:0] s2_metric;
    // S3: best register and end-of-frame tag
    dat_t                 best_cw_d, best_cw_q;
    logic [pMETRIC_W-1:0] best_metric_d, best_metric_q;
    logic                 best_valid_d, best_valid_q;
    logic                 s3_eop_d, s3_eop_q;
    dat_t                 s3_hd_d, s3_hd_q;
    // Output register
    logic                 oval_d, oval_q, ofail_d, ofail_q;
    dat_t                 odat_d, odat_q;
    logic [pMETRIC_W-1:0] ometric_d, ometric_q;
    logic [4:0]           oerr_d, oerr_q;

    // Hard decision and clamped magnitude of the incoming LLRs; the sop beat uses them directly.
    always_comb begin
        for (int i = 0; i < int'(CW_W); i++) begin
            hd_in[i]  = illr[i][pLLR_W-1];
            mag_in[i] = MAG_W'(abs_clamp(16'($signed(illr[i])), pLLR_W));
        end
        take_sop   = ival & isop;
        accept     = ival & (isop | in_frame_q);
        hd_cur     = take_sop ? hd_in : hd_q;
        mag_cur    = take_sop ? mag_in : mag_q;
        hd_d       = hd_cur;
        mag_d      = mag_cur;
        in_frame_d = in_frame_q;
        if (take_sop) begin
            in_frame_d = ~ieop;
        end else if (ival & ieop) begin
            in_frame_d = 1'b0;
        end
        s1_val_d  = accept;
        s1_sop_d  = take_sop;
        s1_eop_d  = accept & ieop;
        s1_fail_d = idec_fail;
        s1_diff_d = icw ^ hd_cur;
        s1_cw_d   = icw;
        s1_hd_d   = hd_cur;
        s1_mag_d  = mag_cur;
    end

    golay24_dec_metric #(
        .pMAG_W    (MAG_W),
        .pMETRIC_W (pMETRIC_W)
    ) u_metric (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .imask   (s1_diff_q),
        .imag    (s1_mag_q),
        .ometric (s2_metric)
    );

    // Compare against best; an sop candidate starts a fresh frame regardless of the old best.
    always_comb begin
        best_cw_d     = best_cw_q;
        best_metric_d = best_metric_q;
        best_valid_d  = best_valid_q;
        if (s2_val_q & s2_sop_q) begin
            best_valid_d = 1'b0;
        end
        if (s2_val_q & ~s2_fail_q &
            (s2_sop_q | ~best_valid_q | (s2_metric < best_metric_q))) begin
            best_cw_d     = s2_cw_q;
            best_metric_d = s2_metric;
            best_valid_d  = 1'b1;
        end
        s3_eop_d = s2_val_q & s2_eop_q;
        s3_hd_d  = s2_hd_q;
    end

    // Form the frame result from the settled best register; hold it between pulses.
    always_comb begin
        oval_d    = s3_eop_q;
        odat_d    = odat_q;
        ometric_d = ometric_q;
        oerr_d    = oerr_q;
        ofail_d   = ofail_q;
        if (s3_eop_q) begin
            odat_d    = best_valid_q ? best_cw_q : s3_hd_q;
            ometric_d = best_valid_q ? best_metric_q : '0;
            ofail_d   = ~best_valid_q;
            oerr_d    = 5'($countones(odat_d ^ s3_hd_q));
        end
    end

    // All pipeline state advances only on enabled edges.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            hd_q          <= '0;
            mag_q         <= '0;
            in_frame_q    <= 1'b0;
            s1_val_q      <= 1'b0;
            s1_sop_q      <= 1'b0;
            s1_eop_q      <= 1'b0;
            s1_fail_q     <= 1'b0;
            s1_diff_q     <= '0;
            s1_cw_q       <= '0;
            s1_hd_q       <= '0;
            s1_mag_q      <= '0;
            s2_val_q      <= 1'b0;
            s2_sop_q      <= 1'b0;
            s2_eop_q      <= 1'b0;
            s2_fail_q     <= 1'b0;
            s2_cw_q       <= '0;
            s2_hd_q       <= '0;
            best_cw_q     <= '0;
            best_metric_q <= '0;
            best_valid_q  <= 1'b0;
            s3_eop_q      <= 1'b0;
            s3_hd_q       <= '0;
            oval_q        <= 1'b0;
            odat_q        <= '0;
            ometric_q     <= '0;
            oerr_q        <= '0;
            ofail_q       <= 1'b0;
        end else if (iclkena) begin
            hd_q          <= hd_d;
            mag_q         <= mag_d;
            in_frame_q    <= in_frame_d;
            s1_val_q      <= s1_val_d;
            s1_sop_q      <= s1_sop_d;
            s1_eop_q      <= s1_eop_d;
            s1_fail_q     <= s1_fail_d;
            s1_diff_q     <= s1_diff_d;
            s1_cw_q       <= s1_cw_d;
            s1_hd_q       <= s1_hd_d;
            s1_mag_q      <= s1_mag_d;
            s2_val_q      <= s1_val_q;
            s2_sop_q      <= s1_sop_q;
            s2_eop_q      <= s1_eop_q;
            s2_fail_q     <= s1_fail_q;
            s2_cw_q       <= s1_cw_q;
            s2_hd_q       <= s1_hd_q;
            best_cw_q     <= best_cw_d;
            best_metric_q <= best_metric_d;
            best_valid_q  <= best_valid_d;
            s3_eop_q      <= s3_eop_d;
            s3_hd_q       <= s3_hd_d;
            oval_q        <= oval_d;
            odat_q        <= odat_d;
            ometric_q     <= ometric_d;
            oerr_q        <= oerr_d;
            ofail_q       <= ofail_d;
        end
    end

    assign oval    = oval_q;
    assign odat    = odat_q;
    assign ometric = ometric_q;
    assign oerr    = oerr_q;
    assign ofail   = ofail_q;

endmodule
